// File: rtl/hunter_ook_pkg.sv
// Shared types and bit-encoding constants for the OOK fan-remote decoder.
package hunter_ook_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  localparam int CHIPS_PER_BIT   = 3;
  localparam int ZERO_HIGH_CHIPS = 1;
  localparam int ONE_HIGH_CHIPS  = 2;
  localparam int FRAME_BITS      = 8;
  localparam int ADDR_MSB        = 7;
  localparam int ADDR_LSB        = 3;

  localparam logic [2:0] CMD_RESET = 3'd7;

endpackage

// File: rtl/ook_sync.sv
// Two-flop synchronizer for the OOK envelope plus registered rise/fall strobes.
module ook_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
      r_prev <= r_sync;
      rise   <= r_sync & ~r_prev;
      fall   <= ~r_sync & r_prev;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/ook_packet_decoder.sv
// OOK pulse-width packet decoder: waits for an idle gap, decodes 8 bits MSB first,
// and reports the 3-bit command when the 5-bit address matches.
module ook_packet_decoder #(
  parameter int         CHIP_CYCLES = 4800,
  parameter int         GAP_CHIPS   = 8,
  parameter logic [4:0] ADDR        = 5'h15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ook_in,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [1:0] dbg_state
);
  import hunter_ook_pkg::*;

  localparam int GAP_CYC = GAP_CHIPS * CHIP_CYCLES;
  localparam int CNT_W   = $clog2(GAP_CYC + 1);
  localparam int TOL     = CHIP_CYCLES / 4;

  localparam logic [CNT_W-1:0] K_GAP      = CNT_W'(GAP_CYC);
  localparam logic [CNT_W-1:0] K_ZERO_MIN = CNT_W'(ZERO_HIGH_CHIPS * CHIP_CYCLES - TOL);
  localparam logic [CNT_W-1:0] K_ZERO_MAX = CNT_W'(ZERO_HIGH_CHIPS * CHIP_CYCLES + TOL);
  localparam logic [CNT_W-1:0] K_ONE_MIN  = CNT_W'(ONE_HIGH_CHIPS * CHIP_CYCLES - TOL);
  localparam logic [CNT_W-1:0] K_ONE_MAX  = CNT_W'(ONE_HIGH_CHIPS * CHIP_CYCLES + TOL);
  localparam logic [CNT_W-1:0] K_LOW_MIN  = CNT_W'((CHIPS_PER_BIT - ONE_HIGH_CHIPS) * CHIP_CYCLES - TOL);
  localparam logic [CNT_W-1:0] K_LOW_MAX  = CNT_W'((CHIPS_PER_BIT - ZERO_HIGH_CHIPS) * CHIP_CYCLES + TOL);

  logic             r_rst_meta;
  logic             r_rst_n;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bits;
  logic [6:0]       r_shift;

  logic             w_s;
  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] w_w;
  logic             w_is_zero;
  logic             w_is_one;
  logic [7:0]       w_frame;
  logic             w_low_ok;

  // Reset asserts immediately but releases two clocks later, aligned to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_n    <= r_rst_meta;
    end
  end

  ook_sync u_sync (
    .clk     (clk),
    .reset_n (r_rst_n),
    .d       (ook_in),
    .q       (w_s),
    .rise    (w_rise),
    .fall    (w_fall)
  );

  // Width including the current cycle, so it equals the pulse length on the strobe cycle.
  assign w_w       = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_is_zero = (w_w >= K_ZERO_MIN) && (w_w <= K_ZERO_MAX);
  assign w_is_one  = (w_w >= K_ONE_MIN) && (w_w <= K_ONE_MAX);
  assign w_low_ok  = (w_w >= K_LOW_MIN) && (w_w <= K_LOW_MAX);
  assign w_frame   = {r_shift, w_is_one};

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bits    <= '0;
      r_shift   <= '0;
      cmd       <= CMD_RESET;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_s) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= w_w;
            if (w_w >= K_GAP) r_state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (w_rise) begin
            r_cnt   <= '0;
            r_bits  <= '0;
            r_state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            r_cnt <= '0;
            if (!(w_is_zero || w_is_one)) begin
              frame_err <= 1'b1;
              r_state   <= ST_IDLE;
            end else if (r_bits == 3'(FRAME_BITS - 1)) begin
              r_state <= ST_IDLE;
              if (w_frame[ADDR_MSB:ADDR_LSB] == ADDR) begin
                cmd       <= w_frame[ADDR_LSB-1:0];
                cmd_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              r_shift <= w_frame[6:0];
              r_bits  <= r_bits + 3'd1;
              r_state <= ST_LOW;
            end
          end else if (w_w >= K_ONE_MAX) begin
            // Still high one cycle past the longest legal pulse.
            frame_err <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= w_w;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            r_cnt <= '0;
            if (w_low_ok) begin
              r_state <= ST_HIGH;
            end else begin
              frame_err <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end else if (w_w >= K_LOW_MAX) begin
            frame_err <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= w_w;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == ST_HIGH) || (r_state == ST_LOW);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ook_packet_decoder.sv
// Bench for ook_packet_decoder: waveform segments feed a segment-level reference
// model that queues expected pulses; a monitor pops and compares on every pulse.
module tb_ook_packet_decoder;

  localparam int C       = 8;
  localparam int G       = 4;
  localparam int T       = C / 4;
  localparam int GAP_CYC = G * C;
  localparam logic [4:0] ADDR = 5'h15;
  localparam int ZMIN = C - T, ZMAX = C + T;
  localparam int OMIN = 2 * C - T, OMAX = 2 * C + T;
  localparam int LMIN = C - T, LMAX = 2 * C + T;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ook_in = 1'b0;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       frame_err;
  logic       busy;
  logic [1:0] dbg_state;

  ook_packet_decoder #(.CHIP_CYCLES(C), .GAP_CHIPS(G), .ADDR(ADDR)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ook_in    (ook_in),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .frame_err (frame_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_vec = 0;
  int         n_miss = 0;
  logic [3:0] exp_q[$];  // {is_err, expected cmd}
  logic [3:0] mon_e;

  // reference model state (whole-segment view of the waveform)
  bit         m_armed = 1'b0;
  bit         m_in_frame = 1'b0;
  int         m_nbits = 0;
  logic [7:0] m_frame = 8'h00;
  logic [2:0] m_cmd = 3'd7;
  bit         model_en = 1'b1;

  bit         lvl_q[$];
  int         len_q[$];
  int         bad_hi[8] = '{3, 4, 5, 11, 12, 13, 19, 24};
  int         bad_lo[5] = '{3, 4, 5, 19, 23};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    m_armed    = 1'b0;
    m_in_frame = 1'b0;
    m_nbits    = 0;
    m_cmd      = 3'd7;
  endfunction

  function automatic void model_high(int len);
    bit b;
    if (len >= ZMIN && len <= ZMAX) b = 1'b0;
    else if (len >= OMIN && len <= OMAX) b = 1'b1;
    else begin
      exp_q.push_back({1'b1, m_cmd});
      m_in_frame = 1'b0;
      return;
    end
    m_frame = {m_frame[6:0], b};
    m_nbits++;
    if (m_nbits == 8) begin
      m_in_frame = 1'b0;
      if (m_frame[7:3] == ADDR) begin
        m_cmd = m_frame[2:0];
        exp_q.push_back({1'b0, m_cmd});
      end else begin
        exp_q.push_back({1'b1, m_cmd});
      end
    end
  endfunction

  function automatic void model_seg(bit lvl, int len);
    int idle_len;
    if (lvl == 1'b0) begin
      idle_len = len;
      if (m_in_frame) begin
        if (len >= LMIN && len <= LMAX) return;
        exp_q.push_back({1'b1, m_cmd});
        m_in_frame = 1'b0;
        idle_len = (len > LMAX) ? len - (LMAX + 1) : 0;
      end
      if (idle_len >= GAP_CYC) m_armed = 1'b1;
    end else if (m_in_frame) begin
      model_high(len);
    end else if (m_armed) begin
      m_armed    = 1'b0;
      m_in_frame = 1'b1;
      m_nbits    = 0;
      model_high(len);
    end
  endfunction

  // ---------------- driver ----------------
  function automatic void add_seg(bit lvl, int len);
    if (lvl_q.size() > 0 && lvl_q[lvl_q.size()-1] == lvl)
      len_q[len_q.size()-1] = len_q[len_q.size()-1] + len;
    else begin
      lvl_q.push_back(lvl);
      len_q.push_back(len);
    end
  endfunction

  function automatic void add_bit(int hi, int lo);
    add_seg(1'b1, hi);
    add_seg(1'b0, lo);
  endfunction

  function automatic void add_frame(int gap, logic [7:0] f, int jit);
    add_seg(1'b0, gap);
    for (int i = 7; i >= 0; i--)
      add_bit((f[i] ? 2 * C : C) + jit, f[i] ? C : 2 * C);
  endfunction

  task automatic play_segs();
    bit l;
    int n;
    while (lvl_q.size() > 0) begin
      l = lvl_q.pop_front();
      n = len_q.pop_front();
      if (model_en) model_seg(l, n);
      ook_in = l;
      repeat (n) @(negedge clk);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
    check(name, 8'(exp_q.size()), 8'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (cmd_valid && frame_err) begin
      n_vec++;
      n_miss++;
      $display("FAIL both_pulses: cmd_valid=1 frame_err=1, expected at most one (t=%0t)", $time);
    end
    if (cmd_valid || frame_err) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_pulse: cmd_valid=%0b frame_err=%0b, expected none (t=%0t)",
                 cmd_valid, frame_err, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_is_err", {7'd0, frame_err}, {7'd0, mon_e[3]});
        check("cmd_at_pulse", {5'd0, cmd}, {5'd0, mon_e[2:0]});
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] f;
    int hi, lo;

    reset_n = 1'b0;
    ook_in  = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_cmd", {5'd0, cmd}, 8'd7);
    check("rst_cmd_valid", {7'd0, cmd_valid}, 8'd0);
    check("rst_frame_err", {7'd0, frame_err}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Widths +3: first '1' high lasts 19 cycles and is rejected, cmd untouched.
    add_frame(GAP_CYC, 8'b10101_010, 3);
    add_seg(1'b0, 40);
    play_segs();
    drain("drain_jit_p3");
    check("cmd_after_jit_p3", {5'd0, cmd}, 8'd7);

    // Exact timing, then +2 and -2 jitter on every high.
    add_frame(GAP_CYC, 8'b10101_010, 0);
    add_seg(1'b0, 40);
    play_segs();
    drain("drain_exact");
    check("cmd_after_exact", {5'd0, cmd}, 8'd2);
    add_frame(40, 8'b10101_011, 2);
    add_frame(40, 8'b10101_010, -2);
    add_seg(1'b0, 40);
    play_segs();
    drain("drain_jit_pm2");
    check("cmd_after_jit_pm2", {5'd0, cmd}, 8'd2);

    // Address mismatch.
    add_frame(40, 8'b00001_011, 0);
    add_seg(1'b0, 40);
    play_segs();
    drain("drain_addr_mismatch");
    check("cmd_after_mismatch", {5'd0, cmd}, 8'd2);

    // Over-long low after bit 4, a frame only 10 cycles later, then a proper gap.
    f = 8'b10101_010;
    add_seg(1'b0, 40);
    for (int i = 7; i >= 4; i--) add_bit(f[i] ? 2 * C : C, f[i] ? C : 2 * C);
    add_seg(1'b1, f[3] ? 2 * C : C);
    add_seg(1'b0, 25 + 10);
    add_frame(0, {ADDR, 3'd1}, 0);
    add_frame(GAP_CYC, {ADDR, 3'd5}, 0);
    add_seg(1'b0, 40);
    play_segs();
    drain("drain_long_low");
    check("cmd_after_long_low", {5'd0, cmd}, 8'd5);

    // Reset during bit 5 discards the partial frame silently.
    f = {ADDR, 3'd1};
    model_en = 1'b0;
    add_seg(1'b0, 40);
    for (int i = 7; i >= 3; i--) add_bit(f[i] ? 2 * C : C, f[i] ? C : 2 * C);
    add_seg(1'b1, 5);
    play_segs();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_cmd", {5'd0, cmd}, 8'd7);
    check("midrst_busy", {7'd0, busy}, 8'd0);
    ook_in  = 1'b0;
    reset_n = 1'b1;
    model_reset();
    model_en = 1'b1;
    add_frame(40, {ADDR, 3'd4}, 0);
    add_seg(1'b0, 40);
    play_segs();
    drain("drain_after_reset");
    check("cmd_after_reset", {5'd0, cmd}, 8'd4);

    // Two identical frames back to back with a 32-cycle gap.
    add_frame(40, {ADDR, 3'd6}, 0);
    add_frame(GAP_CYC, {ADDR, 3'd6}, 0);
    add_seg(1'b0, 40);
    play_segs();
    drain("drain_back_to_back");
    check("cmd_after_b2b", {5'd0, cmd}, 8'd6);

    // Randomized packets with jitter and occasional illegal widths.
    for (int p = 0; p < 40; p++) begin
      f[7:3] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : ADDR;
      f[2:0] = 3'($urandom_range(0, 7));
      add_seg(1'b0, $urandom_range(40, 60));
      for (int i = 7; i >= 0; i--) begin
        hi = (f[i] ? 2 * C : C) + int'($urandom_range(0, 4)) - 2;
        if ($urandom_range(0, 11) == 0) hi = bad_hi[$urandom_range(0, 7)];
        lo = f[i] ? C : 2 * C;
        if (i > 0) begin
          lo = lo + int'($urandom_range(0, 4)) - 2;
          if ($urandom_range(0, 11) == 0) lo = bad_lo[$urandom_range(0, 4)];
        end
        add_bit(hi, lo);
      end
    end
    add_seg(1'b0, 40);
    play_segs();
    drain("drain_random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
